// File: rtl/tt_um_hoene_manchester_encoder.sv
// rtl/tt_um_hoene_manchester_encoder.sv - Manchester line encoder with alternating preamble and back-to-back words
// Each bit drives its level for the first half-period and the inverse for the second half.
module tt_um_hoene_manchester_encoder #(
  parameter int BIT_LENGTH    = 24,
  parameter int DATA_WIDTH    = 8,
  parameter int PREAMBLE_BITS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  out,
  output logic                  out_active
);

  localparam int PH_W     = $clog2(BIT_LENGTH);
  localparam int MAX_BITS = (DATA_WIDTH > PREAMBLE_BITS) ? DATA_WIDTH : PREAMBLE_BITS;
  localparam int BI_W     = (MAX_BITS > 1) ? $clog2(MAX_BITS) : 1;

  localparam logic [PH_W-1:0] PH_LAST   = PH_W'(BIT_LENGTH - 1);
  localparam logic [PH_W-1:0] PH_HALF   = PH_W'(BIT_LENGTH / 2);
  localparam logic [BI_W-1:0] PRE_LAST  = BI_W'(PREAMBLE_BITS - 1);
  localparam logic [BI_W-1:0] DATA_LAST = BI_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PREAMBLE,
    S_DATA
  } state_t;

  state_t                r_state;
  logic [PH_W-1:0]       r_phase;
  logic [BI_W-1:0]       r_bit;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_out;
  logic                  r_active;

  state_t                w_state_nx;
  logic [PH_W-1:0]       w_phase_nx;
  logic [BI_W-1:0]       w_bit_nx;
  logic [DATA_WIDTH-1:0] w_shift_nx;
  logic                  w_out_nx;
  logic                  w_bit_end;
  logic                  w_ready;
  logic                  w_accept;

  assign w_bit_end  = (r_phase == PH_LAST);
  assign w_ready    = ~rst & ((r_state == S_IDLE) ||
                              ((r_state == S_DATA) && w_bit_end && (r_bit == DATA_LAST)));
  assign w_accept   = in_valid & w_ready;
  assign in_ready   = w_ready;
  assign out        = r_out;
  assign out_active = r_active;

  always_comb begin
    w_state_nx = r_state;
    w_phase_nx = r_phase;
    w_bit_nx   = r_bit;
    w_shift_nx = r_shift;
    w_out_nx   = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nx = S_PREAMBLE;
          w_phase_nx = '0;
          w_bit_nx   = '0;
          w_shift_nx = in_data;
        end
      end
      S_PREAMBLE: begin
        if (w_bit_end) begin
          w_phase_nx = '0;
          if (r_bit == PRE_LAST) begin
            w_state_nx = S_DATA;
            w_bit_nx   = '0;
          end else begin
            w_bit_nx = r_bit + 1'b1;
          end
        end else begin
          w_phase_nx = r_phase + 1'b1;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_phase_nx = '0;
          if (r_bit == DATA_LAST) begin
            w_bit_nx = '0;
            // A word accepted here continues the frame without a new preamble
            if (w_accept) begin
              w_shift_nx = in_data;
            end else begin
              w_state_nx = S_IDLE;
            end
          end else begin
            w_bit_nx   = r_bit + 1'b1;
            w_shift_nx = {r_shift[DATA_WIDTH-2:0], 1'b0};
          end
        end else begin
          w_phase_nx = r_phase + 1'b1;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase

    // Line level for the upcoming cycle; preamble starts with 1 on even bit indices
    unique case (w_state_nx)
      S_PREAMBLE: w_out_nx = ~w_bit_nx[0] ^ (w_phase_nx >= PH_HALF);
      S_DATA:     w_out_nx = w_shift_nx[DATA_WIDTH-1] ^ (w_phase_nx >= PH_HALF);
      default:    w_out_nx = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_phase  <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
      r_out    <= 1'b0;
      r_active <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_phase  <= w_phase_nx;
      r_bit    <= w_bit_nx;
      r_shift  <= w_shift_nx;
      r_out    <= w_out_nx;
      r_active <= (w_state_nx != S_IDLE);
    end
  end

endmodule

// File: tb/tb_tt_um_hoene_manchester_encoder.sv
// tb/tb_tt_um_hoene_manchester_encoder.sv - scoreboard bench for the Manchester encoder
// Small instance (BIT_LENGTH=4, PREAMBLE_BITS=2) plus a default instance checked by a half-bit decoder.
module tb_tt_um_hoene_manchester_encoder;

  localparam int BL = 4;
  localparam int PB = 2;
  localparam int DW = 8;
  localparam int DBL = 24;
  localparam int DPB = 8;

  logic clk = 1'b0;
  logic rst;
  logic [DW-1:0] in_data;
  logic in_valid;
  logic in_ready;
  logic out;
  logic out_active;

  logic [DW-1:0] d_data;
  logic d_valid;
  logic d_ready;
  logic d_out;
  logic d_active;

  int errors = 0;
  int checks = 0;

  // Each entry is {in_ready, out_active, out} expected for one cycle
  logic [2:0] sb[$];

  always #5 clk = ~clk;

  tt_um_hoene_manchester_encoder #(
    .BIT_LENGTH(BL), .DATA_WIDTH(DW), .PREAMBLE_BITS(PB)
  ) u_dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out(out), .out_active(out_active)
  );

  tt_um_hoene_manchester_encoder u_def (
    .clk(clk), .rst(rst), .in_data(d_data), .in_valid(d_valid),
    .in_ready(d_ready), .out(d_out), .out_active(d_active)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input logic [DW-1:0] word, input bit with_pre);
    logic v;
    if (with_pre) begin
      for (int b = 0; b < PB; b++) begin
        v = ((b % 2) == 0);
        for (int ph = 0; ph < BL; ph++) sb.push_back({1'b0, 1'b1, (ph < BL/2) ? v : ~v});
      end
    end
    for (int i = DW-1; i >= 0; i--) begin
      v = word[i];
      for (int ph = 0; ph < BL; ph++)
        sb.push_back({(i == 0) && (ph == BL-1), 1'b1, (ph < BL/2) ? v : ~v});
    end
  endtask

  // Called at a negedge with the encoder idle; n is 1 or 2 back-to-back words
  task automatic run_words(input logic [DW-1:0] w0, input logic [DW-1:0] w1, input int n, input string tag);
    logic [2:0] e;
    int acc_cnt;
    logic acc_next;
    int cyc;
    in_data = w0;
    in_valid = 1'b1;
    chk({tag, "_ready_idle"}, in_ready, 1'b1);
    push_frame(w0, 1'b1);
    acc_cnt = 1;
    acc_next = 1'b1;
    cyc = 0;
    while (sb.size() > 0 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      if (acc_next) begin
        if (acc_cnt < n) begin
          in_data = w1;
          push_frame(w1, 1'b0);
          acc_cnt++;
        end else begin
          in_valid = 1'b0;
        end
      end
      e = sb.pop_front();
      chk({tag, "_out"}, out, e[0]);
      chk({tag, "_active"}, out_active, e[1]);
      chk({tag, "_ready"}, in_ready, e[2]);
      acc_next = e[2] & in_valid;
    end
    chk({tag, "_len"}, cyc, (PB + DW) * BL + (n - 1) * DW * BL);
    @(negedge clk);
    chk({tag, "_end_out"}, out, 1'b0);
    chk({tag, "_end_active"}, out_active, 1'b0);
    chk({tag, "_end_ready"}, in_ready, 1'b1);
  endtask

  initial begin
    logic [DW-1:0] word;
    logic [DW-1:0] dec;
    logic h1;
    int derr;
    int ph;
    int bi;

    rst = 1'b1;
    in_data = 8'hC3;
    in_valid = 1'b1;
    d_data = '0;
    d_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out", out, 1'b0);
    chk("rst_active", out_active, 1'b0);
    chk("rst_ready", in_ready, 1'b0);
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("rst_release_ready", in_ready, 1'b1);
    @(negedge clk);
    chk("idle_out", out, 1'b0);

    run_words(8'hA5, 8'h00, 1, "a5");
    run_words(8'hFF, 8'h00, 2, "ff_00");
    run_words(8'h3C, 8'h00, 1, "gap_w0");
    run_words(8'h96, 8'h00, 1, "gap_w1");

    // Reset in the middle of the data phase
    in_data = 8'h5A;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (PB * BL + 6) @(negedge clk);
    chk("mid_active", out_active, 1'b1);
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", in_ready, 1'b0);
    repeat (2) begin
      @(negedge clk);
      chk("mid_rst_out", out, 1'b0);
      chk("mid_rst_active", out_active, 1'b0);
      chk("mid_rst_ready_hold", in_ready, 1'b0);
    end
    rst = 1'b0;
    #1;
    chk("mid_release_ready", in_ready, 1'b1);
    @(negedge clk);
    run_words(8'h81, 8'h00, 1, "post_rst");

    // Default-parameter instance through a mid-half-bit sampling decoder
    for (int w = 0; w < 4; w++) begin
      word = 8'($urandom_range(0, 255));
      d_data = word;
      d_valid = 1'b1;
      chk("loop_ready", d_ready, 1'b1);
      dec = '0;
      derr = 0;
      h1 = 1'b0;
      for (int c = 1; c <= (DPB + DW) * DBL; c++) begin
        @(negedge clk);
        if (c == 1) d_valid = 1'b0;
        ph = (c - 1) % DBL;
        bi = (c - 1) / DBL;
        if (ph == DBL/4) h1 = d_out;
        if (ph == 3*DBL/4 && bi >= DPB) begin
          if (h1 == d_out || !d_active) derr++;
          dec = {dec[DW-2:0], h1};
        end
      end
      chk("loop_word", dec, word);
      chk("loop_err", derr, 0);
      @(negedge clk);
      chk("loop_end_active", d_active, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
